ternary_match_table: RTL and testbench

- Parametrised, registered ternary (value/care-mask) pattern matcher with a programmable entry table.
- Replaces hand-written casex/casez decode where don't-care matching must be explicit and safe.
- Don't-cares live only in the stored care mask. Lookup key bits are always compared literally, so a key bit can never act as a wildcard.
- Two-stage lookup pipeline with priority resolution, a multiple-match flag and saturating hit/miss statistics.

---
 rtl/ternary_match_table.sv | 145 ++++++++++++++
 tb/tb_ternary_match_table.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_match_table.sv
// Ternary value/care-mask matcher with a programmable table, two-stage lookup
// pipeline, lowest-index priority, multi-match flag and saturating statistics.

module tmt_entry #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] wr_value,
  input  logic [WIDTH-1:0] wr_care,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] key,
  output logic             match
);
  logic [WIDTH-1:0] value_q, care_q;
  logic             valid_q;

  // clr only drops the valid bit; value/care are left in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      care_q  <= '0;
      valid_q <= 1'b0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (we) begin
      value_q <= wr_value;
      care_q  <= wr_care;
      valid_q <= wr_valid;
    end
  end

  // key bits are always compared literally; only care_q can mask a bit
  assign match = valid_q && (((key ^ value_q) & care_q) == '0);
endmodule

module ternary_match_table #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_value,
  input  logic [WIDTH-1:0] wr_care,
  input  logic             wr_valid,
  input  logic             lk_valid,
  input  logic [WIDTH-1:0] lk_key,
  output logic             res_valid,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_multi,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] s1_match_q;
  logic [2:1]       vld_pipe_q;
  logic             res_hit_q, res_multi_q;
  logic [IDX_W-1:0] res_idx_q;
  logic             hit_d, multi_d;
  logic [IDX_W-1:0] idx_d;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  // out-of-range wr_idx selects no entry, so the write is dropped
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    tmt_entry #(.WIDTH(WIDTH)) u_ent (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .we       (wr_en && (wr_idx == IDX_W'(g))),
      .wr_value (wr_value),
      .wr_care  (wr_care),
      .wr_valid (wr_valid),
      .key      (lk_key),
      .match    (match[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_match_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], lk_valid};
      if (lk_valid) s1_match_q <= match;
    end
  end

  always_comb begin
    hit_d   = 1'b0;
    multi_d = 1'b0;
    idx_d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (s1_match_q[i]) begin
        if (hit_d) multi_d = 1'b1;
        else begin
          hit_d = 1'b1;
          idx_d = IDX_W'(i);
        end
      end
    end
  end

  // result fields hold while no result is being produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
      res_multi_q <= 1'b0;
    end else if (vld_pipe_q[1]) begin
      res_hit_q   <= hit_d;
      res_idx_q   <= idx_d;
      res_multi_q <= multi_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (vld_pipe_q[2]) begin
      if (res_hit_q) begin
        if (hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != CNT_MAX) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign res_valid = vld_pipe_q[2];
  assign res_hit   = res_hit_q;
  assign res_idx   = res_idx_q;
  assign res_multi = res_multi_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_ternary_match_table.sv
// Bench for ternary_match_table: spec-level model checked every cycle on two
// instances (CNT_W=8 and CNT_W=2), plus literal expectations from the test plan.
module tb_ternary_match_table;
  localparam int WIDTH = 3;
  localparam int DEPTH = 4;

  logic clk = 0, rst = 1, clr = 0, wr_en = 0, wr_valid = 0, lk_valid = 0;
  logic [1:0] wr_idx = '0;
  logic [WIDTH-1:0] wr_value = '0, wr_care = '0, lk_key = '0;

  logic res_valid, res_hit, res_multi;
  logic [1:0] res_idx;
  logic [7:0] hit_cnt, miss_cnt;
  logic res_valid2, res_hit2, res_multi2;
  logic [1:0] res_idx2;
  logic [1:0] hit_cnt2, miss_cnt2;

  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  ternary_match_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_value(wr_value), .wr_care(wr_care), .wr_valid(wr_valid),
    .lk_valid(lk_valid), .lk_key(lk_key),
    .res_valid(res_valid), .res_hit(res_hit), .res_idx(res_idx),
    .res_multi(res_multi), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  ternary_match_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_value(wr_value), .wr_care(wr_care), .wr_valid(wr_valid),
    .lk_valid(lk_valid), .lk_key(lk_key),
    .res_valid(res_valid2), .res_hit(res_hit2), .res_idx(res_idx2),
    .res_multi(res_multi2), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_val [DEPTH];
  logic [WIDTH-1:0] m_care[DEPTH];
  bit m_vld[DEPTH];
  // lookup results in flight: index 0 = sampled last edge, 1 = visible now
  bit   q_v[2];
  bit   q_hit[2], q_multi[2];
  int   q_idx[2];
  bit   e_valid, e_hit, e_multi;
  int   e_idx;
  int   e_hc, e_mc, e_hc2, e_mc2;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        q_v[0] = 0; q_v[1] = 0;
        e_valid = 0; e_hit = 0; e_multi = 0; e_idx = 0;
        e_hc = 0; e_mc = 0; e_hc2 = 0; e_mc2 = 0;
      end else begin
        if (e_valid) begin
          if (e_hit) begin
            if (e_hc < 255) e_hc++;
            if (e_hc2 < 3) e_hc2++;
          end else begin
            if (e_mc < 255) e_mc++;
            if (e_mc2 < 3) e_mc2++;
          end
        end
        e_valid = q_v[0];
        if (q_v[0]) begin
          e_hit = q_hit[0]; e_idx = q_idx[0]; e_multi = q_multi[0];
        end
        q_v[0] = lk_valid;
        if (lk_valid) begin
          int n;
          n = 0; q_idx[0] = 0;
          for (int i = DEPTH - 1; i >= 0; i--)
            if (m_vld[i] && (((lk_key ^ m_val[i]) & m_care[i]) == 0)) begin
              n++; q_idx[0] = i;
            end
          q_hit[0] = (n > 0); q_multi[0] = (n > 1);
        end
        if (clr) for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        else if (wr_en && int'(wr_idx) < DEPTH) begin
          m_val[wr_idx] = wr_value; m_care[wr_idx] = wr_care; m_vld[wr_idx] = wr_valid;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("res_valid", res_valid, e_valid);
      chk("res_hit", res_hit, e_hit);
      chk("res_idx", res_idx, e_idx);
      chk("res_multi", res_multi, e_multi);
      chk("hit_cnt", hit_cnt, e_hc);
      chk("miss_cnt", miss_cnt, e_mc);
      chk("res_valid2", res_valid2, e_valid);
      chk("res_hit2", res_hit2, e_hit);
      chk("res_idx2", res_idx2, e_idx);
      chk("hit_cnt2", hit_cnt2, e_hc2);
      chk("miss_cnt2", miss_cnt2, e_mc2);
    end
  end

  // result log {hit, idx, multi} for the literal checks
  logic [3:0] rlog[$];
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid) rlog.push_back({res_hit, res_idx, res_multi});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    lk_valid = 0; wr_en = 0; clr = 0;
  endtask

  task automatic wr(input int idx, input logic [2:0] v, input logic [2:0] c, input bit vl);
    wr_en = 1; wr_idx = 2'(idx); wr_value = v; wr_care = c; wr_valid = vl;
  endtask

  task automatic lk(input logic [2:0] k);
    lk_valid = 1; lk_key = k;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_log(input string name, input logic [3:0] exp);
    logic [3:0] got;
    if (rlog.size() == 0) begin
      chk({name, "_missing"}, 32'd0, 32'd1);
    end else begin
      got = rlog.pop_front();
      chk(name, got, exp);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_hitcnt", hit_cnt, 0);
    chk("rst_misscnt", miss_cnt, 0);
    rst = 0;
    tick();

    // test 1: two entries, three keys back to back
    rlog.delete();
    wr(0, 3'b100, 3'b101, 1); tick();
    wr(1, 3'b000, 3'b101, 1); tick();
    lk(3'b110); tick();
    lk(3'b010); tick();
    lk(3'b111); tick();
    idle(4);
    chk_log("t1_k110", 4'b1000);
    chk_log("t1_k010", 4'b1010);
    chk_log("t1_k111", 4'b0000);
    chk("t1_hitcnt", hit_cnt, 2);
    chk("t1_misscnt", miss_cnt, 1);

    // test 2: catch-all entry 2 -> multi-match
    rlog.delete();
    wr(2, 3'b000, 3'b000, 1); tick();
    lk(3'b110); tick();
    lk(3'b011); tick();
    idle(4);
    chk_log("t2_k110", 4'b1001);
    chk_log("t2_k011", 4'b1100);
    chk("t2_hitcnt2_sat", hit_cnt2, 3);

    // test 3: write and lookup in the same cycle sees old contents
    rlog.delete();
    wr(2, 3'b000, 3'b000, 0); tick();
    wr(3, 3'b111, 3'b111, 1); lk(3'b111); tick();
    lk(3'b111); tick();
    idle(4);
    chk_log("t3_same_cycle", 4'b0000);
    chk_log("t3_next_cycle", 4'b1110);

    // test 4: clr beats a simultaneous write; counters untouched
    rlog.delete();
    clr = 1; wr(0, 3'b100, 3'b101, 1); tick();
    lk(3'b100); tick();
    idle(4);
    chk_log("t4_after_clr", 4'b0000);
    chk("t4_hitcnt", hit_cnt, 5);
    chk("t4_misscnt", miss_cnt, 3);

    // test 5: reset with lookups in flight
    wr(0, 3'b100, 3'b101, 1); tick();
    lk(3'b100); tick();
    lk(3'b100);
    #2 rst = 1;
    #1;
    chk("t5_rst_valid", res_valid, 0);
    chk("t5_rst_hit", res_hit, 0);
    chk("t5_rst_idx", res_idx, 0);
    chk("t5_rst_multi", res_multi, 0);
    chk("t5_rst_hitcnt", hit_cnt, 0);
    chk("t5_rst_misscnt", miss_cnt, 0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    rlog.delete();
    idle(4);
    chk("t5_no_result", rlog.size(), 0);

    // test 6: empty table, five misses saturate the 2-bit counter
    lk(3'b100); tick();
    lk(3'b000); tick();
    lk(3'b111); tick();
    lk(3'b010); tick();
    lk(3'b101); tick();
    idle(4);
    chk_log("t6_k100", 4'b0000);
    chk("t6_misscnt", miss_cnt, 5);
    chk("t6_misscnt2_sat", miss_cnt2, 3);
    chk("t6_hitcnt2", hit_cnt2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
